// File: rtl/cic_integrator_chain.sv
// -----------------------------------------------------------------------------
// cic_integrator_chain
//
// Integrator section of a CIC decimator/interpolator: N_STAGES cascaded
// accumulators, each adding the previous stage's registered value into its own
// register whenever a valid sample wave passes through it. The arithmetic is
// plain two's-complement modulo 2^ACC_W. Wrap-around inside the chain is
// intentional, because the following comb section cancels it. The output is the
// top OUT_W bits of the last accumulator (truncation, no rounding).
//
// Parameters
//   IN_W      signed input sample width                (default 16)
//   ACC_W     signed accumulator width, ACC_W >= IN_W  (default 32)
//   N_STAGES  number of cascaded integrators, 1..8     (default 3)
//   OUT_W     output width, OUT_W <= ACC_W             (default 32)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset; clears every register
//   bypass     (only with CIC_INTEGRATOR_BYPASS_EN) route the entering sample
//              around the integrators through an N_STAGES delay line
//   in_valid   d_in carries a sample this cycle
//   d_in       signed input sample, IN_W bits
//   out_valid  d_out carries a result this cycle (N_STAGES cycles after entry)
//   d_out      signed result, top OUT_W bits of the last accumulator; holds
//              its value between valid cycles
//
// Build option
//   CIC_INTEGRATOR_BYPASS_EN  adds the bypass port and its delay line. When
//                             undefined, the port and its logic do not exist.
// -----------------------------------------------------------------------------
module cic_integrator_chain #(
  parameter int IN_W     = 16,
  parameter int ACC_W    = 32,
  parameter int N_STAGES = 3,
  parameter int OUT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef CIC_INTEGRATOR_BYPASS_EN
  input  logic                    bypass,
`endif
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  d_in,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] d_out
);

  // Sign-extend an input sample to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_in(input logic signed [IN_W-1:0] x);
    logic signed [ACC_W-1:0] r;
    r = x;
    return r;
  endfunction

  // Keep the top OUT_W bits of an accumulator value. The discarded LSBs are
  // dropped without rounding.
  function automatic logic signed [OUT_W-1:0] trunc_out(input logic signed [ACC_W-1:0] a);
    return a[ACC_W-1 -: OUT_W];
  endfunction

  // The declaration initialisers match the reset values, so simulation starts
  // from the same state that reset produces.
  logic signed [ACC_W-1:0] acc_q [N_STAGES] = '{default: '0};
  logic signed [ACC_W-1:0] acc_d [N_STAGES];
  logic [N_STAGES-1:0]     vld_q = '0;
  logic [N_STAGES-1:0]     vld_d;

  // adv_en[i]: stage i takes an integrating step this cycle, meaning a valid
  // non-bypassed sample wave is entering it.
  logic [N_STAGES-1:0]     adv_en;

`ifdef CIC_INTEGRATOR_BYPASS_EN
  // The bypass delay line runs parallel to the integrators. Each slot holds
  // the mode flag and the raw (sign-extended) sample. Slots advance only
  // together with a valid wave, so the last slot keeps the mode of the most
  // recent output and d_out holds correctly between valid cycles.
  logic [N_STAGES-1:0]     byp_q = '0;
  logic [N_STAGES-1:0]     byp_d;
  logic signed [ACC_W-1:0] bdat_q [N_STAGES] = '{default: '0};
  logic signed [ACC_W-1:0] bdat_d [N_STAGES];

  always_comb begin
    adv_en    = '0;
    adv_en[0] = in_valid & ~bypass;
    for (int i = 1; i < N_STAGES; i++) begin
      adv_en[i] = vld_q[i-1] & ~byp_q[i-1];
    end
  end

  always_comb begin
    byp_d  = byp_q;
    bdat_d = bdat_q;
    if (in_valid) begin
      byp_d[0]  = bypass;
      bdat_d[0] = sext_in(d_in);
    end
    for (int i = 1; i < N_STAGES; i++) begin
      if (vld_q[i-1]) begin
        byp_d[i]  = byp_q[i-1];
        bdat_d[i] = bdat_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_q  <= '0;
      bdat_q <= '{default: '0};
    end else begin
      byp_q  <= byp_d;
      bdat_q <= bdat_d;
    end
  end
`else
  always_comb begin
    adv_en    = '0;
    adv_en[0] = in_valid;
    for (int i = 1; i < N_STAGES; i++) begin
      adv_en[i] = vld_q[i-1];
    end
  end
`endif

  // Integrator stages: each stage reads the previous stage's registered value,
  // so a sample wave moves one stage per cycle. Gaps simply leave every stage
  // untouched, which keeps the output sequence independent of gap placement.
  always_comb begin
    acc_d    = acc_q;
    vld_d    = '0;
    vld_d[0] = in_valid;
    if (adv_en[0]) begin
      acc_d[0] = acc_q[0] + sext_in(d_in);
    end
    for (int i = 1; i < N_STAGES; i++) begin
      vld_d[i] = vld_q[i-1];
      if (adv_en[i]) begin
        acc_d[i] = acc_q[i] + acc_q[i-1];
      end
    end
  end

  // Stage registers. Reset takes priority over an incoming sample and flushes
  // every wave that is still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '{default: '0};
      vld_q <= '0;
    end else begin
      acc_q <= acc_d;
      vld_q <= vld_d;
    end
  end

  // Output stage: a registered value only, with no path from d_in.
  assign out_valid = vld_q[N_STAGES-1];

`ifdef CIC_INTEGRATOR_BYPASS_EN
  assign d_out = byp_q[N_STAGES-1] ? trunc_out(bdat_q[N_STAGES-1])
                                   : trunc_out(acc_q[N_STAGES-1]);
`else
  assign d_out = trunc_out(acc_q[N_STAGES-1]);
`endif

endmodule

// File: tb/tb_cic_integrator_chain.sv
// -----------------------------------------------------------------------------
// tb_cic_integrator_chain
//
// Self-checking bench for cic_integrator_chain. It drives three instances:
//   dut0: default parameters (N=3, 16->32->32)
//   dut1: N=1, 8-bit input/accumulator/output (wrap-around and gap cases)
//   dut2: N=2, IN_W=12, ACC_W=20, OUT_W=10 (truncation)
//
// The reference model keeps the list of valid samples accepted since the last
// reset. Each expected output is the N-fold running sum of that list, wrapped
// to ACC_W bits and shifted down by ACC_W-OUT_W bits. The expected result is
// due exactly N rising edges after the sample is latched.
// -----------------------------------------------------------------------------
module tb_cic_integrator_chain;

  localparam int NS0 = 3, IW0 = 16, AW0 = 32, OW0 = 32;
  localparam int NS1 = 1, IW1 = 8,  AW1 = 8,  OW1 = 8;
  localparam int NS2 = 2, IW2 = 12, AW2 = 20, OW2 = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                  v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic signed [IW0-1:0] d0 = '0;
  logic signed [IW1-1:0] d1 = '0;
  logic signed [IW2-1:0] d2 = '0;
  logic                  ov0, ov1, ov2;
  logic signed [OW0-1:0] od0;
  logic signed [OW1-1:0] od1;
  logic signed [OW2-1:0] od2;
`ifdef CIC_INTEGRATOR_BYPASS_EN
  logic                  b0 = 1'b0;
  logic                  b1 = 1'b0;
  logic                  b2 = 1'b0;
`endif

  cic_integrator_chain #(.IN_W(IW0), .ACC_W(AW0), .N_STAGES(NS0), .OUT_W(OW0)) dut0 (
    .clk(clk), .rst(rst),
`ifdef CIC_INTEGRATOR_BYPASS_EN
    .bypass(b0),
`endif
    .in_valid(v0), .d_in(d0), .out_valid(ov0), .d_out(od0));

  cic_integrator_chain #(.IN_W(IW1), .ACC_W(AW1), .N_STAGES(NS1), .OUT_W(OW1)) dut1 (
    .clk(clk), .rst(rst),
`ifdef CIC_INTEGRATOR_BYPASS_EN
    .bypass(b1),
`endif
    .in_valid(v1), .d_in(d1), .out_valid(ov1), .d_out(od1));

  cic_integrator_chain #(.IN_W(IW2), .ACC_W(AW2), .N_STAGES(NS2), .OUT_W(OW2)) dut2 (
    .clk(clk), .rst(rst),
`ifdef CIC_INTEGRATOR_BYPASS_EN
    .bypass(b2),
`endif
    .in_valid(v2), .d_in(d2), .out_valid(ov2), .d_out(od2));

  typedef struct {
    int     due;
    longint val;
  } pend_t;

  int     n_checks = 0;
  int     n_errors = 0;
  int     pcount   = 0;
  longint smp  [3][$];
  pend_t  pend [3][$];
  longint cap  [3][$];
  longint last [3];

  function automatic int ns_of(input int id);
    case (id)
      0:       return NS0;
      1:       return NS1;
      default: return NS2;
    endcase
  endfunction

  function automatic int aw_of(input int id);
    case (id)
      0:       return AW0;
      1:       return AW1;
      default: return AW2;
    endcase
  endfunction

  function automatic int ow_of(input int id);
    case (id)
      0:       return OW0;
      1:       return OW1;
      default: return OW2;
    endcase
  endfunction

  // Interpret the low w bits of r as a signed w-bit number.
  function automatic longint wrap_s(input longint r, input int w);
    longint m;
    m = r << (64 - w);
    return m >>> (64 - w);
  endfunction

  // N-fold running sum of the whole accepted sample history; the last element
  // is the value the final integrator must hold after the newest sample.
  function automatic longint model_out(input longint s[$], input int n, input int aw, input int ow);
    longint a[$];
    longint r;
    a = s;
    for (int st = 0; st < n; st++) begin
      r = 0;
      for (int k = 0; k < a.size(); k++) begin
        r    = r + a[k];
        a[k] = r;
      end
    end
    return wrap_s(a[a.size()-1], aw) >>> (aw - ow);
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_push(input int id, input bit byp, input longint x);
    longint v;
    if (byp) begin
      v = wrap_s(x, aw_of(id)) >>> (aw_of(id) - ow_of(id));
    end else begin
      smp[id].push_back(x);
      v = model_out(smp[id], ns_of(id), aw_of(id), ow_of(id));
    end
    pend[id].push_back('{due: pcount + ns_of(id), val: v});
  endtask

  task automatic model_reset();
    for (int id = 0; id < 3; id++) begin
      smp[id].delete();
      pend[id].delete();
      last[id] = 0;
    end
  endtask

  task automatic check_dut(input int id, input bit ov, input longint od);
    bit     exp_v;
    longint exp_d;
    exp_v = 1'b0;
    exp_d = last[id];
    if (pend[id].size() > 0 && pend[id][0].due == pcount) begin
      exp_v    = 1'b1;
      exp_d    = pend[id][0].val;
      last[id] = exp_d;
      void'(pend[id].pop_front());
    end
    chk($sformatf("dut%0d_out_valid@%0d", id, pcount), longint'(ov), longint'(exp_v));
    chk($sformatf("dut%0d_d_out@%0d", id, pcount), od, exp_d);
    if (ov) cap[id].push_back(od);
  endtask

  task automatic check_all();
    check_dut(0, ov0, od0);
    check_dut(1, ov1, od1);
    check_dut(2, ov2, od2);
  endtask

  // One clock cycle: apply inputs at the falling edge, update the model, then
  // check all outputs at the next falling edge.
  task automatic cyc(input bit r, input bit va, input longint xa, input bit ba,
                     input bit vb, input longint xb, input bit vc, input longint xc);
    rst = r;
    v0  = va; d0 = xa[IW0-1:0];
    v1  = vb; d1 = xb[IW1-1:0];
    v2  = vc; d2 = xc[IW2-1:0];
`ifdef CIC_INTEGRATOR_BYPASS_EN
    b0  = ba;
`endif
    if (r) begin
      model_reset();
    end else begin
      if (va) model_push(0, ba, xa);
      if (vb) model_push(1, 1'b0, xb);
      if (vc) model_push(2, 1'b0, xc);
    end
    @(posedge clk);
    pcount++;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic clear_caps();
    for (int id = 0; id < 3; id++) cap[id].delete();
  endtask

  task automatic expect_seq(input int id, input string tag, input longint exp[$]);
    chk({tag, "_count"}, longint'(cap[id].size()), longint'(exp.size()));
    for (int k = 0; k < exp.size() && k < cap[id].size(); k++) begin
      chk($sformatf("%s_%0d", tag, k), cap[id][k], exp[k]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    longint q[$];
    model_reset();

    // Power-up state before any clock edge.
    #1;
    check_all();
    @(negedge clk);
    check_all();

    // Reset state.
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    cyc(1'b1, 1'b1, 5, 1'b0, 1'b1, 5, 1'b1, 5);
    idle(1);

    // Impulse on dut0; step with gaps on dut1.
    clear_caps();
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, (k < 5), (k == 0) ? 1 : 0, 1'b0,
          ((k % 2) == 0) && (k < 8), 1, 1'b0, 0);
    end
    idle(2);
    q = '{1, 3, 6, 10, 15};
    expect_seq(0, "impulse", q);
    q = '{1, 2, 3, 4};
    expect_seq(1, "step_gaps", q);

    // Negative impulse on dut0; 8-bit wrap-around on dut1.
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    clear_caps();
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, (k < 4), (k == 0) ? -1 : 0, 1'b0, (k < 2), 100, 1'b0, 0);
    end
    q = '{-1, -3, -6, -10};
    expect_seq(0, "neg_impulse", q);
    q = '{100, -56};
    expect_seq(1, "wrap8", q);

    // Reset with two samples in flight and a sample offered during reset.
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    clear_caps();
    cyc(1'b0, 1'b1, 5, 1'b0, 1'b0, 0, 1'b0, 0);
    cyc(1'b0, 1'b1, 7, 1'b0, 1'b0, 0, 1'b0, 0);
    cyc(1'b1, 1'b1, 9, 1'b0, 1'b0, 0, 1'b0, 0);
    idle(4);
    chk("flushed_outputs", longint'(cap[0].size()), 0);
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    clear_caps();
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, (k == 0) ? 1 : 0, 1'b0, 1'b0, 0, 1'b0, 0);
    idle(4);
    q = '{1, 3, 6, 10, 15};
    expect_seq(0, "impulse_after_rst", q);

`ifdef CIC_INTEGRATOR_BYPASS_EN
    // Bypassed sample followed by a normal impulse.
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    clear_caps();
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, (k < 4), (k == 0) ? -7 : ((k == 1) ? 1 : 0), (k == 0), 1'b0, 0, 1'b0, 0);
    end
    q = '{-7, 1, 3, 6};
    expect_seq(0, "bypass", q);
`endif

    // Randomised traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      logic signed [IW0-1:0] ra;
      logic signed [IW1-1:0] rb;
      logic signed [IW2-1:0] rc;
      bit                    r;
      bit                    ba;
      longint                xa, xb, xc;
      ra = IW0'($urandom);
      rb = IW1'($urandom);
      rc = IW2'($urandom);
      xa = ra;
      xb = rb;
      xc = rc;
      r  = ($urandom_range(0, 59) == 0);
`ifdef CIC_INTEGRATOR_BYPASS_EN
      ba = ($urandom_range(0, 4) == 0);
`else
      ba = 1'b0;
`endif
      cyc(r, ($urandom_range(0, 9) < 7), xa, ba,
             ($urandom_range(0, 9) < 6), xb,
             ($urandom_range(0, 9) < 8), xc);
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
